// File: rtl/sum_it_up_param_if.sv
// Start/term/result bundle between a stream source and the sum_it_up_param accumulator.
// Widths follow the accumulator parameters; count width is derived from the term cap.
interface sum_it_up_param_if #(
  parameter int W         = 8,
  parameter int SUM_W     = 8,
  parameter int MAX_TERMS = 255
);
  localparam int CW = $clog2(MAX_TERMS + 1);

  logic             go_l;
  logic [W-1:0]     inA;
  logic             done;
  logic             busy;
  logic [SUM_W-1:0] sum;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (output go_l, inA, input done, busy, sum, count, overflow);
  modport slave  (input go_l, inA, output done, busy, sum, count, overflow);
endinterface

// File: rtl/sum_it_up_param.sv
// Unsigned stream accumulator: falling go_l starts a run, a zero term or the term cap ends it.
// First term sampled one edge after start, done pulses the cycle after the last term; no backpressure.
module sum_it_up_param #(
  parameter int W         = 8,
  parameter int SUM_W     = 8,
  parameter int MAX_TERMS = 255,
  parameter int SATURATE  = 0
) (
  input logic              ck,
  input logic              reset,
  sum_it_up_param_if.slave bus
);
  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             go_q;
  logic             start;
  logic             term_zero;
  logic             cap_hit;
  logic             ovf_add;
  logic [SUM_W:0]   add_t;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_add;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             overflow_q;
  logic             done_d;
  logic             busy_d;

  // go_q resets high so a go_l already low right after reset still counts as a start
  assign start     = (state == IDLE) && !bus.go_l && go_q;
  assign term_zero = (bus.inA == '0);
  assign add_t     = {1'b0, sum_q} + (SUM_W + 1)'(bus.inA);
  assign ovf_add   = add_t[SUM_W];
  assign sum_add   = (ovf_add && (SATURATE != 0)) ? '1 : add_t[SUM_W-1:0];
  assign count_nxt = count_q + CW'(1);
  assign cap_hit   = (count_nxt == CW'(MAX_TERMS));

  always_ff @(posedge ck) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (term_zero || cap_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_d = (state == DONE);
    busy_d = (state == ACCUM);
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      go_q       <= 1'b1;
    end else begin
      go_q <= bus.go_l;
      if (start) begin
        sum_q      <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if ((state == ACCUM) && !term_zero) begin
        sum_q   <= sum_add;
        count_q <= count_nxt;
        if (ovf_add) overflow_q <= 1'b1;
      end
    end
  end

  assign bus.done     = done_d;
  assign bus.busy     = busy_d;
  assign bus.sum      = sum_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sum_it_up_param.sv
// Four accumulator configurations share one stimulus stream; results are checked against
// hand-derived tables and a run-level arithmetic model.
module tb_sum_it_up_param;
  logic       ck = 1'b0;
  logic       reset = 1'b1;
  logic       go_l = 1'b1;
  logic [7:0] inA = 8'd0;

  always #5 ck = ~ck;

  // cfg 0: wrap, cfg 1: saturate, cfg 2: cap of 4, cfg 3: 12-bit sum
  int cfg_sw [4] = '{8, 8, 8, 12};
  int cfg_max[4] = '{255, 255, 4, 255};
  int cfg_sat[4] = '{0, 1, 0, 0};

  sum_it_up_param_if #(.W(8), .SUM_W(8),  .MAX_TERMS(255)) if0 ();
  sum_it_up_param_if #(.W(8), .SUM_W(8),  .MAX_TERMS(255)) if1 ();
  sum_it_up_param_if #(.W(8), .SUM_W(8),  .MAX_TERMS(4))   if2 ();
  sum_it_up_param_if #(.W(8), .SUM_W(12), .MAX_TERMS(255)) if3 ();

  assign if0.go_l = go_l;  assign if0.inA = inA;
  assign if1.go_l = go_l;  assign if1.inA = inA;
  assign if2.go_l = go_l;  assign if2.inA = inA;
  assign if3.go_l = go_l;  assign if3.inA = inA;

  sum_it_up_param #(.W(8), .SUM_W(8),  .MAX_TERMS(255), .SATURATE(0)) u0 (.ck(ck), .reset(reset), .bus(if0.slave));
  sum_it_up_param #(.W(8), .SUM_W(8),  .MAX_TERMS(255), .SATURATE(1)) u1 (.ck(ck), .reset(reset), .bus(if1.slave));
  sum_it_up_param #(.W(8), .SUM_W(8),  .MAX_TERMS(4),   .SATURATE(0)) u2 (.ck(ck), .reset(reset), .bus(if2.slave));
  sum_it_up_param #(.W(8), .SUM_W(12), .MAX_TERMS(255), .SATURATE(0)) u3 (.ck(ck), .reset(reset), .bus(if3.slave));

  logic        o_done[4];
  logic        o_busy[4];
  logic        o_ovf [4];
  logic [31:0] o_sum [4];
  logic [31:0] o_cnt [4];

  assign o_done[0] = if0.done;  assign o_busy[0] = if0.busy;  assign o_ovf[0] = if0.overflow;
  assign o_done[1] = if1.done;  assign o_busy[1] = if1.busy;  assign o_ovf[1] = if1.overflow;
  assign o_done[2] = if2.done;  assign o_busy[2] = if2.busy;  assign o_ovf[2] = if2.overflow;
  assign o_done[3] = if3.done;  assign o_busy[3] = if3.busy;  assign o_ovf[3] = if3.overflow;
  assign o_sum[0] = 32'(if0.sum);  assign o_cnt[0] = 32'(if0.count);
  assign o_sum[1] = 32'(if1.sum);  assign o_cnt[1] = 32'(if1.count);
  assign o_sum[2] = 32'(if2.sum);  assign o_cnt[2] = 32'(if2.count);
  assign o_sum[3] = 32'(if3.sum);  assign o_cnt[3] = 32'(if3.count);

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Run-level model: walks the term list with plain integer arithmetic.
  // m is the negedge index (1 = first negedge after the start edge) at which done is visible.
  task automatic model(input int cfg, input int q[$], output int s, output int c,
                       output int o, output int m);
    int lim;
    lim = 1 << cfg_sw[cfg];
    s = 0; c = 0; o = 0; m = q.size() + 2;
    for (int j = 0; j < q.size(); j++) begin
      if (q[j] == 0) begin m = j + 2; break; end
      s = s + q[j];
      c = c + 1;
      if (s >= lim) begin
        o = 1;
        s = (cfg_sat[cfg] != 0) ? lim - 1 : s % lim;
      end
      if (c == cfg_max[cfg]) begin m = j + 2; break; end
    end
  endtask

  // Starts a run at the current negedge, streams q, checks latency, results and hold.
  task automatic run_q(input int q[$], input int es[4], input int ec[4], input int eo[4],
                       input string tag);
    int em[4];
    int fm[4];
    int dn[4];
    int s_, c_, o_;
    for (int i = 0; i < 4; i++) begin
      model(i, q, s_, c_, o_, em[i]);
      fm[i] = -1;
      dn[i] = 0;
    end
    go_l = 1'b0;
    inA  = 8'd0;
    @(negedge ck);
    go_l = 1'b1;
    for (int i = 0; i < 4; i++) chk($sformatf("%s d%0d busy_after_start", tag, i), int'(o_busy[i]), 1);
    inA = (q.size() > 0) ? 8'(q[0]) : 8'd0;
    for (int m = 2; m <= q.size() + 4; m++) begin
      @(negedge ck);
      for (int i = 0; i < 4; i++) begin
        if (o_done[i]) begin
          dn[i]++;
          if (fm[i] < 0) begin
            fm[i] = m;
            chk($sformatf("%s d%0d sum", tag, i), int'(o_sum[i]), es[i]);
            chk($sformatf("%s d%0d count", tag, i), int'(o_cnt[i]), ec[i]);
            chk($sformatf("%s d%0d overflow", tag, i), int'(o_ovf[i]), eo[i]);
          end
        end
      end
      inA = (m - 1 < q.size()) ? 8'(q[m-1]) : 8'd0;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s d%0d done_latency", tag, i), fm[i], em[i]);
      chk($sformatf("%s d%0d done_pulses", tag, i), dn[i], 1);
    end
    repeat (10) @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s d%0d sum_held", tag, i), int'(o_sum[i]), es[i]);
      chk($sformatf("%s d%0d count_held", tag, i), int'(o_cnt[i]), ec[i]);
      chk($sformatf("%s d%0d busy_idle", tag, i), int'(o_busy[i]), 0);
    end
  endtask

  typedef struct {
    int a; int na;
    int b; int nb;
    int c; int nc;
    int es[4];
    int ec[4];
    int eo[4];
  } vec_t;

  vec_t tbl[7];

  initial begin
    int q[$];
    int es[4], ec[4], eo[4], em;
    int bad;

    tbl[0] = '{3,   1,  5,   1, 7, 1, '{15, 15, 15, 15},     '{3, 3, 3, 3},     '{0, 0, 0, 0}};
    tbl[1] = '{200, 1,  100, 1, 0, 0, '{44, 255, 44, 300},   '{2, 2, 2, 2},     '{1, 1, 1, 0}};
    tbl[2] = '{100, 1,  0,   0, 0, 0, '{100, 100, 100, 100}, '{1, 1, 1, 1},     '{0, 0, 0, 0}};
    tbl[3] = '{1,   6,  0,   0, 0, 0, '{6, 6, 4, 6},         '{6, 6, 4, 6},     '{0, 0, 0, 0}};
    tbl[4] = '{0,   0,  0,   0, 0, 0, '{0, 0, 0, 0},         '{0, 0, 0, 0},     '{0, 0, 0, 0}};
    tbl[5] = '{255, 16, 0,   0, 0, 0, '{240, 255, 252, 4080}, '{16, 16, 4, 16}, '{1, 1, 1, 0}};
    tbl[6] = '{255, 17, 0,   0, 0, 0, '{239, 255, 252, 239}, '{17, 17, 4, 17},  '{1, 1, 1, 1}};

    repeat (2) @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset d%0d sum", i), int'(o_sum[i]), 0);
      chk($sformatf("reset d%0d count", i), int'(o_cnt[i]), 0);
      chk($sformatf("reset d%0d flags", i), {o_done[i], o_busy[i], o_ovf[i]}, 0);
    end
    reset = 1'b0;
    @(negedge ck);

    for (int k = 0; k < 7; k++) begin
      q.delete();
      repeat (tbl[k].na) q.push_back(tbl[k].a);
      repeat (tbl[k].nb) q.push_back(tbl[k].b);
      repeat (tbl[k].nc) q.push_back(tbl[k].c);
      q.push_back(0);
      run_q(q, tbl[k].es, tbl[k].ec, tbl[k].eo, $sformatf("vec%0d", k));
    end

    // go_l held low through done must not restart until it has been seen high
    go_l = 1'b0;
    inA  = 8'd0;
    @(negedge ck);
    for (int i = 0; i < 4; i++) chk($sformatf("hold_low d%0d busy", i), int'(o_busy[i]), 1);
    @(negedge ck);
    for (int i = 0; i < 4; i++) chk($sformatf("hold_low d%0d done", i), int'(o_done[i]), 1);
    bad = 0;
    repeat (5) begin
      @(negedge ck);
      for (int i = 0; i < 4; i++) if (o_busy[i] || o_done[i]) bad++;
    end
    chk("hold_low no_restart", bad, 0);
    go_l = 1'b1;
    @(negedge ck);
    go_l = 1'b0;
    @(negedge ck);
    for (int i = 0; i < 4; i++) chk($sformatf("rearm d%0d busy", i), int'(o_busy[i]), 1);
    go_l = 1'b1;
    repeat (3) @(negedge ck);

    // reset in the middle of a run, then a start on the first cycle after reset
    go_l = 1'b0;
    @(negedge ck);
    go_l = 1'b1;
    inA  = 8'd9;
    repeat (2) @(negedge ck);
    chk("midrun d0 sum_before_reset", int'(o_sum[0]), 18);
    reset = 1'b1;
    @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("midrun d%0d sum", i), int'(o_sum[i]), 0);
      chk($sformatf("midrun d%0d count", i), int'(o_cnt[i]), 0);
      chk($sformatf("midrun d%0d busy_done", i), {o_busy[i], o_done[i]}, 0);
    end
    reset = 1'b0;
    go_l  = 1'b0;
    @(negedge ck);
    for (int i = 0; i < 4; i++) chk($sformatf("post_reset d%0d busy", i), int'(o_busy[i]), 1);
    go_l = 1'b1;
    inA  = 8'd2;
    @(negedge ck);
    inA = 8'd0;
    @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_reset d%0d done", i), int'(o_done[i]), 1);
      chk($sformatf("post_reset d%0d sum", i), int'(o_sum[i]), 2);
    end
    repeat (2) @(negedge ck);

    for (int r = 0; r < 25; r++) begin
      q.delete();
      repeat ($urandom_range(0, 20)) begin
        if ($urandom_range(0, 3) == 0) q.push_back(255);
        else q.push_back(int'($urandom_range(1, 255)));
      end
      q.push_back(0);
      for (int i = 0; i < 4; i++) model(i, q, es[i], ec[i], eo[i], em);
      run_q(q, es, ec, eo, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/sum_it_up_param.md
Name: sum_it_up_param

Overview:
Parametrised successor to the 8-bit sumItUp accumulator. After a go_l start request, it sums a stream of unsigned values presented on inA, one per clock. The run ends on a zero terminator or when a term-count cap is reached. It then raises done for one cycle and holds sum, count and overflow status for the downstream thread and the seven-segment display path. It adds configurable data and sum widths, a term cap, a saturate/wrap overflow mode and an edge-armed start.

Parameters:
W, 8, width of inA in bits (unsigned).
SUM_W, 8, width of sum in bits; must be >= W.
MAX_TERMS, 255, maximum number of non-zero terms accepted per run; must be >= 1.
SATURATE, 0, overflow mode: 0 = wrap modulo 2^SUM_W, 1 = clamp sum to all-ones.

Ports:
ck  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
go_l  input  1  active-low start request; level sampled each cycle.
inA  input  W  data term; sampled once per cycle while busy.
done  output  1  one-cycle pulse: run complete, results valid.
busy  output  1  high while accumulating.
sum  output  SUM_W  accumulated sum; held after done until the next start.
count  output  CW = $clog2(MAX_TERMS+1)  number of non-zero terms accumulated.
overflow  output  1  sticky flag: at least one addition exceeded 2^SUM_W-1 during the run.

Behaviour:
- Reset (reset=1 at a ck edge):
  - state=IDLE; sum=0, count=0, overflow=0, done=0, busy=0.
  - go_q=1, where go_q is the registered previous go_l.
  - Reset has priority over every other event, including mid-run; the next cycle is IDLE with zeroed outputs.
- Start detect:
  - start = (state==IDLE) && !go_l && go_q.
  - This is a high-to-low edge, or go_l low on the first cycle after reset.
  - go_q <= go_l every cycle.
- States: IDLE, ACCUM, DONE; encoding is free.
- IDLE:
  - On start: clear sum, count and overflow at that edge; next state ACCUM.
  - Otherwise hold all outputs.
  - go_l held low after a run does not restart; it must be sampled high at least once first.
- ACCUM (busy=1), evaluated at each edge:
  - If inA==0: terminator, nothing added, next state DONE.
  - Else form the (SUM_W+1)-bit add t = sum + zero-extended inA, and increment count.
    - If t[SUM_W]=1: overflow<=1. Then sum<=t[SUM_W-1:0] if SATURATE=0, or sum<={SUM_W{1'b1}} if SATURATE=1.
    - Once saturated, further adds keep sum at all-ones with overflow=1.
    - If the new count == MAX_TERMS: next state DONE; no terminator is needed.
  - go_l is ignored while in ACCUM.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next state is IDLE unconditionally; inA is ignored.
  - A start request cannot be accepted in DONE.
- Latency:
  - Start sampled at edge T means the first term is sampled at edge T+1.
  - A terminator or cap-reaching term sampled at edge k means done is high in the cycle after edge k.
  - Minimum run is go, then 0: done two cycles after the start edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. W=8, SUM_W=8, SAT=0: go_l pulse low, inA=3,5,7,0 on successive cycles -> done one cycle after the 0 is sampled; sum=15, count=3, overflow=0; values held 10 cycles later.
2. Wrap (SAT=0): inA=200,100,0 -> sum=44, count=2, overflow=1. Same stream with SAT=1 -> sum=255, overflow=1. Second SAT=1 run 100,0 -> sum=100, overflow=0 (cleared on start).
3. Cap (MAX_TERMS=4): inA=1 on six consecutive cycles, no zero -> done after the 4th term; sum=4, count=4; the 5th and 6th values are not added.
4. Immediate terminator: start, then inA=0 -> done two cycles after the start edge; sum=0, count=0. Hold go_l low through done and 5 more cycles -> no restart. Raise go_l, then lower it -> a new run starts.
5. Reset mid-run: after terms 9,9 (sum=18), assert reset for 1 cycle -> next cycle sum=0, count=0, busy=0, done stays 0. A new run 2,0 -> sum=2.
6. SUM_W=12, W=8: inA=255 sixteen times, then 0 -> sum=4080, count=16, overflow=0. With MAX_TERMS=255 and 17 terms of 255 -> sum=4335 mod 4096=239, overflow=1.
